// File: rtl/cpu_trace_streamer.sv
// cpu_trace_streamer: commit-trace sink for the single-cycle MIPS CPU.
// Captures the CPU's per-cycle debug values into a small record FIFO and
// serializes each record as an 18-byte packet on a valid/ready byte stream.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   trace_en              capture this cycle's CPU state
//   pc, instr, pcNext,
//   aluResult             32-bit CPU trace values
//   aluZero, regWrite,
//   branch, aluSrc,
//   memWrite              CPU trace flags
//   tx_data/valid/last    byte stream out (tx_last marks byte 17)
//   tx_ready              sink accepts the byte
//   fifo_level            records currently buffered (0..DEPTH)
//   drop_cnt              saturating count of records dropped on a full FIFO
module cpu_trace_streamer #(
    parameter int unsigned DEPTH = 4,
    parameter logic [7:0]  SYNC  = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trace_en,
    input  logic [31:0]             pc,
    input  logic [31:0]             instr,
    input  logic [31:0]             pcNext,
    input  logic [31:0]             aluResult,
    input  logic                    aluZero,
    input  logic                    regWrite,
    input  logic                    branch,
    input  logic                    aluSrc,
    input  logic                    memWrite,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    output logic                    tx_last,
    input  logic                    tx_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             drop_cnt
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned RW      = 136;  // flags + four 32-bit words
    localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);
    localparam logic [4:0]  LastIdx = 5'd17;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_last_q, tx_last_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [15:0]       drop_q, drop_d;
    logic              lost_q, lost_d;

    logic [RW-1:0]     mem_q [DEPTH];
    logic [RW-1:0]     rec_in;
    logic [RW+7:0]     pkt;
    logic              push, pop, drop;
    logic [4:0]        nxt_idx;
    logic [7:0]        bit_off;

    // Record storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rec_in;
        end
    end

    always_comb begin
        rec_in = {lost_q, 2'b00, memWrite, aluSrc, branch, regWrite, aluZero,
                  pc, instr, pcNext, aluResult};
        pkt    = {SYNC, mem_q[rd_ptr_q]};

        pop  = (state_q == StSend) && tx_ready && (idx_q == LastIdx);
        // A completing pop frees a slot on the same edge, so a full FIFO still accepts.
        push = trace_en && ((level_q < FullLvl) || pop);
        drop = trace_en && !push;

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
        drop_d   = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        lost_d   = drop ? 1'b1 : (push ? 1'b0 : lost_q);

        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        nxt_idx    = idx_q + 5'd1;
        bit_off    = 8'd0;

        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    state_d    = StSend;
                    idx_d      = 5'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC;
                    tx_last_d  = 1'b0;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d     = 5'd0;
                        tx_last_d = 1'b0;
                        // Byte 0 is the constant SYNC, so the next head need not be read yet.
                        if (level_d != '0) begin
                            tx_data_d = SYNC;
                        end else begin
                            state_d    = StIdle;
                            tx_valid_d = 1'b0;
                            tx_data_d  = 8'd0;
                        end
                    end else begin
                        idx_d     = nxt_idx;
                        bit_off   = {LastIdx - nxt_idx, 3'b000};
                        tx_data_d = pkt[bit_off +: 8];
                        tx_last_d = (nxt_idx == LastIdx);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= 5'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= 16'd0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            lost_q     <= lost_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_last    = tx_last_q;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_cpu_trace_streamer.sv
// Self-checking bench for cpu_trace_streamer: a reference model predicts
// accepted records and pushes their packet bytes to a scoreboard queue; a
// monitor pops and compares each byte as the DUT hands it over.
module tb_cpu_trace_streamer;

    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic        clk;
    logic        rst_n;
    logic        trace_en;
    logic [31:0] pc, instr, pcNext, aluResult;
    logic        aluZero, regWrite, branch, aluSrc, memWrite;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last, tx_ready;
    logic [2:0]  fifo_level;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Scoreboard and reference model state
    logic [8:0]  exp_q[$];     // {last, byte}
    logic [7:0]  obs_log[$];
    int          m_lvl;
    logic [15:0] m_drop;
    logic        m_lost;
    logic        pop_pending;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;

    cpu_trace_streamer #(
        .DEPTH (DEPTH),
        .SYNC  (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trace_en   (trace_en),
        .pc         (pc),
        .instr      (instr),
        .pcNext     (pcNext),
        .aluResult  (aluResult),
        .aluZero    (aluZero),
        .regWrite   (regWrite),
        .branch     (branch),
        .aluSrc     (aluSrc),
        .memWrite   (memWrite),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [31:0] p, input logic [31:0] i, input logic [31:0] pn,
                           input logic [31:0] a, input logic [4:0] f);
        pc        = p;
        instr     = i;
        pcNext    = pn;
        aluResult = a;
        {memWrite, aluSrc, branch, regWrite, aluZero} = f;
    endtask

    task automatic capture();
        trace_en = 1'b1;
        tick();
        trace_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic done;
        done     = 1'b0;
        tx_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (fifo_level == 0 && !tx_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    // Reference model: decides push/drop at each edge from the bench's own state.
    always @(posedge clk or negedge rst_n) begin
        logic         push;
        logic         pop;
        logic [143:0] rec;
        if (!rst_n) begin
            m_lvl  = 0;
            m_drop = 16'd0;
            m_lost = 1'b0;
            exp_q.delete();
        end else begin
            pop  = pop_pending;
            push = trace_en && (m_lvl < DEPTH || pop);
            if (trace_en && !push) begin
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                m_lost = 1'b1;
            end
            if (push) begin
                rec = {SYNC, m_lost, 2'b00, memWrite, aluSrc, branch, regWrite, aluZero,
                       pc, instr, pcNext, aluResult};
                for (int k = 0; k < 18; k++) begin
                    exp_q.push_back({k == 17, rec[143:136]});
                    rec = rec << 8;
                end
                m_lost = 1'b0;
            end
            m_lvl = m_lvl + int'(push) - int'(pop);
        end
    end

    // Monitor: sampled mid-cycle, sees what the next rising edge will consume.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            prev_stall  = 1'b0;
            pop_pending = 1'b0;
        end else begin
            chk("fifo_level", {29'd0, fifo_level}, m_lvl);
            chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop});
            if (prev_stall) begin
                chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
                chk("hold_last", {31'd0, tx_last}, {31'd0, prev_last});
            end
            pop_pending = 1'b0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", {23'd0, tx_last, tx_data}, {23'd0, e});
                    pop_pending = e[8];
                end
                obs_log.push_back(tx_data);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    initial begin
        logic [7:0] golden [18];
        logic       found;
        golden = '{8'hA5, 8'h0A, 8'h00, 8'h40, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00,
                   8'h05, 8'h00, 8'h40, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h05};

        rst_n    = 1'b0;
        trace_en = 1'b0;
        tx_ready = 1'b0;
        set_rec(32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        repeat (3) tick();
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_last", {31'd0, tx_last}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single record with known encoding and latency
        tx_ready = 1'b1;
        set_rec(32'h00400000, 32'h20080005, 32'h00400004, 32'h5, 5'b01010);
        obs_log.delete();
        capture();
        chk("lat_level", {29'd0, fifo_level}, 32'd1);
        chk("lat_valid0", {31'd0, tx_valid}, 32'd0);
        tick();
        chk("lat_sync", {24'd0, tx_data}, {24'd0, SYNC});
        for (int i = 0; i < 18; i++) begin
            chk("single_valid", {31'd0, tx_valid}, 32'd1);
            tick();
        end
        chk("single_end", {31'd0, tx_valid}, 32'd0);
        chk("single_len", obs_log.size(), 32'd18);
        for (int i = 0; i < 18 && i < obs_log.size(); i++) begin
            chk("single_byte", {24'd0, obs_log[i]}, {24'd0, golden[i]});
        end

        // Backpressure on two back-to-back random records
        tx_ready = 1'b0;
        set_rec($urandom, $urandom, $urandom, $urandom, 5'($urandom));
        capture();
        set_rec($urandom, $urandom, $urandom, $urandom, 5'($urandom));
        capture();
        for (int i = 0; i < 90; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain("bp_drain");

        // Overflow: 10 captures into a stalled 4-deep FIFO
        obs_log.delete();
        tx_ready = 1'b0;
        trace_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_rec(32'h1000 + i, 32'h0, 32'h0, 32'h0, 5'd0);
            tick();
        end
        trace_en = 1'b0;
        chk("ovf_level", {29'd0, fifo_level}, 32'd4);
        chk("ovf_drop", {16'd0, drop_cnt}, 32'd6);
        tx_ready = 1'b1;
        found    = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (fifo_level == 3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("ovf_first_pop", {31'd0, found}, 32'd1);
        set_rec(32'h2000, 32'h1, 32'h2, 32'h3, 5'd0);
        capture();
        drain("ovf_drain");
        chk("ovf_len", obs_log.size(), 32'd90);
        for (int k = 0; k < 5 && 18 * k + 1 < obs_log.size(); k++) begin
            chk("ovf_lost_bit", {31'd0, obs_log[18 * k + 1][7]}, {31'd0, k == 4});
        end

        // Push on the same edge as the byte-17 pop with the FIFO full
        tx_ready = 1'b0;
        trace_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_rec(32'h3000 + i, 32'h0, 32'h0, 32'h0, 5'b00001);
            tick();
        end
        trace_en = 1'b0;
        chk("sim_full", {29'd0, fifo_level}, 32'd4);
        tx_ready = 1'b1;
        found    = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (tx_valid && tx_last) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("sim_reach_last", {31'd0, found}, 32'd1);
        set_rec(32'h4000, 32'h0, 32'h0, 32'h0, 5'b10000);
        capture();
        chk("sim_level", {29'd0, fifo_level}, 32'd4);
        chk("sim_drop", {16'd0, drop_cnt}, 32'd6);
        drain("sim_drain");

        // Reset in the middle of a packet
        tx_ready = 1'b1;
        set_rec(32'hDEAD0000, 32'h1, 32'h2, 32'h3, 5'd0);
        capture();
        repeat (9) tick();
        chk("mid_valid", {31'd0, tx_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_last", {31'd0, tx_last}, 32'd0);
        chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
        obs_log.delete();
        tick();
        rst_n = 1'b1;
        set_rec(32'hCAFE1234, 32'h11, 32'h22, 32'h33, 5'b00100);
        capture();
        drain("mid_drain");
        chk("mid_len", obs_log.size(), 32'd18);
        if (obs_log.size() >= 6) begin
            chk("mid_sync", {24'd0, obs_log[0]}, {24'd0, SYNC});
            chk("mid_pc", {obs_log[2], obs_log[3], obs_log[4], obs_log[5]}, 32'hCAFE1234);
        end

        // Drop counter saturation
        tx_ready = 1'b0;
        trace_en = 1'b1;
        repeat (70000) tick();
        trace_en = 1'b0;
        chk("sat_drop", {16'd0, drop_cnt}, 32'h0000FFFF);
        chk("sat_level", {29'd0, fifo_level}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_trace_streamer.md
# cpu_trace_streamer

Hardware commit-trace sink for the single-cycle MIPS `CPU`. It consumes the CPU's per-cycle debug outputs (`pc`, `instr`, `pcNext`, `aluResult` and the control flags) and buffers selected cycles as records in a small FIFO. Each record is serialized as an 18-byte packet on a valid/ready byte stream, so a UART or logic-analyzer port can replay the same information a simulation monitor prints. It sits beside `CPU` at the top level, wired directly to the CPU's trace ports.

## Interface
- `DEPTH`, 4: FIFO capacity in records; power of two, minimum 2.
- `SYNC`, 8'hA5: packet header byte.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `trace_en`  in  1  capture this cycle's CPU state.
- `pc`, `instr`, `pcNext`, `aluResult`  in  32 each  CPU trace values.
- `aluZero`, `regWrite`, `branch`, `aluSrc`, `memWrite`  in  1 each  CPU trace flags.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_last`  out  1  current byte is the final (18th) byte of a packet.
- `tx_ready`  in  1  sink accepts the byte.
- `fifo_level`  out  $clog2(DEPTH)+1  records currently buffered.
- `drop_cnt`  out  16  records dropped because the FIFO was full; saturates at 16'hFFFF.

## Operation
- **Capture:** on each rising edge with `trace_en`=1, the block forms a record from the input values present at that edge.
- **Push rule:** the record is pushed if `fifo_level` < `DEPTH`, or if a pop completes on the same edge. Otherwise it is dropped.
- **Drop handling:** a drop increments `drop_cnt` (saturating) and sets an internal `lost` flag.
- **Lost flag:** `lost` is stored into the next record actually pushed, then cleared on that push. A drop and a push never occur on the same edge.
- **Packet layout (byte index 0 to 17):**
  - 0: `SYNC`.
  - 1: flags = {lost, 2'b00, memWrite, aluSrc, branch, regWrite, aluZero}.
  - 2 to 5: `pc`, MSB first.
  - 6 to 9: `instr`, MSB first.
  - 10 to 13: `pcNext`, MSB first.
  - 14 to 17: `aluResult`, MSB first.
- **FSM states:**
  - IDLE: `tx_valid`=0, `tx_data`=0, `tx_last`=0. Moves to SEND with byte index 0 when `fifo_level` ≠ 0.
  - SEND: `tx_valid`=1, and `tx_data` is byte[index] of the FIFO head record. When `tx_valid && tx_ready`, the index increments.
- **End of packet:** on the handshake of byte 17, the head record is popped. The FSM stays in SEND with index 0 if another record remains after the pop; otherwise it returns to IDLE.
- **Stream rule:** while `tx_valid && !tx_ready`, `tx_data` and `tx_last` hold stable. `tx_valid` never drops mid-packet.
- **Width rules:** the byte index is 5 bits with range 0 to 17. `fifo_level` is the true count and never exceeds `DEPTH`.

## Timing
- **Reset:** on `rst_n`=0, immediately and asynchronously:
  - FSM to IDLE, byte index 0.
  - FIFO empty, `fifo_level`=0.
  - `drop_cnt`=0, `lost`=0.
  - `tx_valid`=0, `tx_data`=0, `tx_last`=0.
- **Reset mid-packet:** a partially sent packet is abandoned, with no tail bytes after release. After release, the first capture happens on the first rising edge with `rst_n`=1.
- **Latency:** capture at edge E gives `fifo_level`≥1 after E, and `tx_valid`=1 with the SYNC byte after edge E+1.
- **Throughput:** with `tx_ready` held high, one packet takes 18 cycles, and back-to-back packets have no idle cycle between them.
- **Occupancy updates:** `fifo_level` and `drop_cnt` update on the same edge as the push, pop or drop.
- **Sustained rate:** continuous `trace_en` exceeds output bandwidth. This is expected, and the drop path must keep the FIFO consistent indefinitely.

## Test plan
- **Single record:** pc=0x00400000, instr=0x20080005, pcNext=0x00400004, aluResult=0x5, regWrite=1, aluSrc=1, one `trace_en` pulse, `tx_ready`=1. Expect the bytes A5, 0A, 00 40 00 00, 20 08 00 05, 00 40 00 04, 00 00 00 05, with `tx_last` on the 18th byte only. Expect `tx_valid` high exactly 18 cycles, starting 2 edges after capture.
- **Backpressure:** toggle `tx_ready` pseudo-randomly during a packet. Expect each byte to hold stable until its handshake, the packet content to be unchanged, and no dropped or duplicated bytes.
- **Overflow:** `DEPTH`=4, `tx_ready`=0, `trace_en`=1 for 10 cycles. Expect `fifo_level`=4 and `drop_cnt`=6. Then pulse one more capture after a pop. Expect that packet's flags bit7=1, and the four earlier packets to have bit7=0.
- **Simultaneous push and pop at full:** capture on the same edge as the byte-17 handshake with the FIFO full. Expect the push accepted, `fifo_level` unchanged at `DEPTH`, and `drop_cnt` unchanged.
- **Reset mid-packet:** assert `rst_n`=0 between edges after byte 7. Expect all outputs to go to zero before the next edge, and after release the next packet to start with A5 and contain only newly captured data.
- **Drop counter saturation:** hold `tx_ready`=0 and `trace_en`=1 for 70000 cycles. Expect `drop_cnt` to stick at 16'hFFFF and `fifo_level` to remain 4.
